// File: rtl/music_pkg.sv
// Shared types and sizes for the note record/playback path.
package music_pkg;

    localparam int MAX_NOTES = 16;
    localparam int ADDR_W    = 4;
    localparam int COUNT_W   = 5;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REC_STROBE  = 3'd1,
        PLAY_LOAD   = 3'd2,
        PLAY_SETTLE = 3'd3,
        PLAY_NOTE   = 3'd4,
        PLAY_GAP    = 3'd5
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/note_sequencer_ctrl_if.sv
// User controls in, datapath strobes/status out, plus the FSM state for observation.
interface note_sequencer_ctrl_if
    import music_pkg::*;
    ;

    // Strobe semantics: ld_note and ld_play are single-cycle pulses the datapath
    // acts on unconditionally; there is no back-pressure. Button inputs are
    // synchronised levels, and only their rising edges are acted on (stop/clear
    // act on level).
    logic               key_press;
    logic               rec_mode;
    logic               play_btn;
    logic               stop_btn;
    logic               clear_btn;
    logic               ld_note;
    logic               ld_play;
    logic [ADDR_W-1:0]  note_counter;
    logic               sound_en;
    logic [COUNT_W-1:0] note_count;
    logic               full;
    logic               playing;
    seq_state_t         state;

    modport master (
        output key_press, rec_mode, play_btn, stop_btn, clear_btn,
        input  ld_note, ld_play, note_counter, sound_en, note_count, full, playing, state
    );

    modport slave (
        input  key_press, rec_mode, play_btn, stop_btn, clear_btn,
        output ld_note, ld_play, note_counter, sound_en, note_count, full, playing, state
    );

endinterface

// File: rtl/note_timer.sv
// Loadable down-counter; done pulses in the last cycle of a loaded interval.
module note_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A value of N loaded at a phase entry yields done in that phase's N-th cycle.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/note_sequencer_ctrl.sv
// Record/playback controller for the note memory. Define LOOP_PLAY_EN to repeat
// playback while play_btn stays high; otherwise playback is a single pass.
module note_sequencer_ctrl
    import music_pkg::*;
#(
    parameter int NOTE_CYCLES   = 12_500_000,
    parameter int GAP_CYCLES    = 1_250_000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    note_sequencer_ctrl_if.slave  bus
);

    localparam int TW = $clog2(max3(NOTE_CYCLES, GAP_CYCLES, SETTLE_CYCLES)) + 1;
    localparam logic [TW-1:0] NOTE_V   = TW'(NOTE_CYCLES);
    localparam logic [TW-1:0] GAP_V    = TW'(GAP_CYCLES);
    localparam logic [TW-1:0] SETTLE_V = TW'(SETTLE_CYCLES);

    seq_state_t         state, state_next;
    logic [COUNT_W-1:0] note_count, count_next;
    logic [COUNT_W-1:0] played, played_next;
    logic [ADDR_W-1:0]  addr, addr_next;
    logic               key_q, play_q, primed;
    logic               key_rise, play_rise;
    logic               ld_note_r, ld_play_r, sound_r, full_r, playing_r;
    logic               tmr_load, tmr_done, note_end, in_play;
    logic [TW-1:0]      tmr_val;

    // primed masks the first cycle after reset so a level held through reset is not an edge.
    assign key_rise  = bus.key_press & ~key_q & primed;
    assign play_rise = bus.play_btn & ~play_q & primed;
    assign in_play   = (state == PLAY_LOAD) || (state == PLAY_SETTLE) ||
                       (state == PLAY_NOTE) || (state == PLAY_GAP);

    note_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_next  = state;
        count_next  = note_count;
        played_next = played;
        addr_next   = addr;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        note_end    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.clear_btn) begin
                    count_next = '0;
                end else if (play_rise && (note_count != '0)) begin
                    state_next  = PLAY_LOAD;
                    addr_next   = ADDR_W'(1);
                    played_next = COUNT_W'(1);
                end else if (key_rise && bus.rec_mode && !full_r) begin
                    state_next = REC_STROBE;
                end
            end
            REC_STROBE: begin
                count_next = note_count + 1'b1;
                state_next = IDLE;
            end
            PLAY_LOAD: begin
                if (SETTLE_CYCLES > 0) begin
                    state_next = PLAY_SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_V;
                end else begin
                    state_next = PLAY_NOTE;
                    tmr_load   = 1'b1;
                    tmr_val    = NOTE_V;
                end
            end
            PLAY_SETTLE: begin
                if (tmr_done) begin
                    state_next = PLAY_NOTE;
                    tmr_load   = 1'b1;
                    tmr_val    = NOTE_V;
                end
            end
            PLAY_NOTE: begin
                if (tmr_done) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = PLAY_GAP;
                        tmr_load   = 1'b1;
                        tmr_val    = GAP_V;
                    end else begin
                        note_end = 1'b1;
                    end
                end
            end
            PLAY_GAP: begin
                if (tmr_done) note_end = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (note_end) begin
            if (played < note_count) begin
                state_next  = PLAY_LOAD;
                addr_next   = addr + 1'b1;
                played_next = played + 1'b1;
            end else begin
`ifdef LOOP_PLAY_EN
                if (bus.play_btn) begin
                    state_next  = PLAY_LOAD;
                    addr_next   = ADDR_W'(1);
                    played_next = COUNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
        end

        // Stop and clear override any playback progress made this cycle.
        if (in_play && (bus.stop_btn || bus.clear_btn)) begin
            state_next = IDLE;
            tmr_load   = 1'b0;
            addr_next  = addr;
            if (bus.clear_btn) count_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            note_count <= '0;
            played     <= '0;
            addr       <= '0;
            key_q      <= 1'b0;
            play_q     <= 1'b0;
            primed     <= 1'b0;
            ld_note_r  <= 1'b0;
            ld_play_r  <= 1'b0;
            sound_r    <= 1'b0;
            full_r     <= 1'b0;
            playing_r  <= 1'b0;
        end else begin
            state      <= state_next;
            note_count <= count_next;
            played     <= played_next;
            addr       <= addr_next;
            key_q      <= bus.key_press;
            play_q     <= bus.play_btn;
            primed     <= 1'b1;
            ld_note_r  <= (state_next == REC_STROBE);
            ld_play_r  <= (state_next == PLAY_LOAD);
            sound_r    <= (state_next == PLAY_NOTE);
            full_r     <= (count_next == COUNT_W'(MAX_NOTES));
            playing_r  <= (state_next == PLAY_LOAD) || (state_next == PLAY_SETTLE) ||
                          (state_next == PLAY_NOTE) || (state_next == PLAY_GAP);
        end
    end

    assign bus.ld_note      = ld_note_r;
    assign bus.ld_play      = ld_play_r;
    assign bus.note_counter = addr;
    assign bus.sound_en     = sound_r;
    assign bus.note_count   = note_count;
    assign bus.full         = full_r;
    assign bus.playing      = playing_r;
    assign bus.state        = state;

endmodule
